pwm_peripheral: RTL and testbench

Register bank and PWM generator directly downstream of the SPI peripheral. Accepts validated write transactions (address 0x00–0x04, 8-bit data) and holds the five control registers. Drives 16 output pins, each either forced low, forced high, or driven by a shared 8-bit PWM waveform. Duty-cycle changes take effect only at a PWM period boundary, so the output never glitches mid-period.

---
 rtl/pwm_peripheral.sv | 86 ++++++++
 tb/tb_pwm_peripheral.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// Five-register write-only control bank feeding a shared 8-bit PWM generator.
// Sixteen output pins: forced low, forced high, or driven by the PWM waveform.
module pwm_peripheral #(
  parameter int unsigned CLK_DIV     = 13,
  parameter logic [7:0]  MAX_ADDRESS = 8'h04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  output logic [15:0] out,
  output logic        pwm_period_start
);

  localparam int unsigned   PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [6:0] {
    REG_OUT_LO = 7'h00,
    REG_OUT_HI = 7'h01,
    REG_PWM_LO = 7'h02,
    REG_PWM_HI = 7'h03,
    REG_DUTY   = 7'h04
  } reg_addr_e;

  logic [15:0]   en_out;
  logic [15:0]   en_pwm;
  logic [7:0]    duty_reg;
  logic [7:0]    duty_active;
  logic [PW-1:0] prescaler;
  logic [7:0]    pwm_cnt;

  logic tick;
  logic boundary;
  logic accept;
  logic addr_bad;
  logic pwm_sig;

  always_comb begin
    wr_ready = ~rst;
    accept   = wr_valid & wr_ready;
    addr_bad = {1'b0, wr_addr} > MAX_ADDRESS;
    tick     = (prescaler == PRE_LAST);
    boundary = tick && (pwm_cnt == 8'hFF);
    pwm_sig  = (duty_active == 8'hFF) || (pwm_cnt < duty_active);
  end

  // duty_active samples duty_reg before this edge's write lands, so a duty
  // write coinciding with the boundary only takes effect one period later.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_out           <= '0;
      en_pwm           <= '0;
      duty_reg         <= '0;
      duty_active      <= '0;
      prescaler        <= '0;
      pwm_cnt          <= '0;
      out              <= '0;
      wr_err           <= 1'b0;
      pwm_period_start <= 1'b0;
    end else begin
      prescaler        <= tick ? '0 : prescaler + PW'(1);
      pwm_period_start <= boundary;
      wr_err           <= accept & addr_bad;
      if (tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (boundary)
        duty_active <= duty_reg;
      if (accept && !addr_bad) begin
        case (wr_addr)
          REG_OUT_LO: en_out[7:0]  <= wr_data;
          REG_OUT_HI: en_out[15:8] <= wr_data;
          REG_PWM_LO: en_pwm[7:0]  <= wr_data;
          REG_PWM_HI: en_pwm[15:8] <= wr_data;
          REG_DUTY:   duty_reg     <= wr_data;
          default:    ;
        endcase
      end
      out <= en_out & (~en_pwm | {16{pwm_sig}});
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral: table of single writes plus period-level
// sequences for duty alignment, boundary-coincident writes and mid-period reset.
module tb_pwm_peripheral;

  localparam int PERIOD = 256 * 13;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic [15:0] out;
  logic        pwm_period_start;

  int checks = 0;
  int errors = 0;

  pwm_peripheral #(.CLK_DIV(13), .MAX_ADDRESS(8'h04)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_valid         (wr_valid),
    .wr_ready         (wr_ready),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .wr_err           (wr_err),
    .out              (out),
    .pwm_period_start (pwm_period_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  typedef struct {
    logic [6:0]  addr;
    logic [7:0]  data;
    logic        exp_err;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_pps(input string name);
    logic seen;
    seen = 1'b0;
    for (int unsigned n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (pwm_period_start) begin
        seen = 1'b1;
        break;
      end
    end
    chk(name, seen, 1);
  endtask

  // Samples out[0] over one full period starting the cycle after a pps cycle.
  task automatic measure(input logic hook, input logic [7:0] hdata,
                         output int hi, output int trans,
                         output logic first, output logic last);
    logic prev;
    hi    = 0;
    trans = 0;
    prev  = 1'b0;
    first = 1'b0;
    for (int unsigned i = 1; i <= PERIOD; i++) begin
      @(negedge clk);
      if (i == 1) first = out[0];
      else if (out[0] != prev) trans++;
      prev = out[0];
      if (out[0]) hi++;
      if (hook && i == PERIOD - 1) begin
        wr_valid = 1'b1;
        wr_addr  = 7'h04;
        wr_data  = hdata;
      end else begin
        wr_valid = 1'b0;
      end
    end
    last = prev;
  endtask

  task automatic reset_and_count(input string tag);
    int   n;
    logic nonzero;
    rst      = 1'b1;
    wr_valid = 1'b1;
    wr_addr  = 7'h00;
    wr_data  = 8'hFF;
    @(negedge clk);
    chk({tag, "_rst_out"}, out, 0);
    chk({tag, "_rst_pps"}, pwm_period_start, 0);
    chk({tag, "_rst_err"}, wr_err, 0);
    chk({tag, "_rst_ready"}, wr_ready, 0);
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk({tag, "_ready_after"}, wr_ready, 1);
    n       = 0;
    nonzero = 1'b0;
    while (n < 4000) begin
      @(negedge clk);
      n++;
      if (out != 16'h0000 || wr_err) nonzero = 1'b1;
      if (pwm_period_start) break;
    end
    chk({tag, "_first_pps_cycle"}, n, PERIOD);
    chk({tag, "_out_zero_until_pps"}, nonzero, 0);
  endtask

  initial begin
    int   hi, trans;
    logic first, last;

    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;

    vecs[0] = '{7'h00, 8'hFF, 1'b0, 16'h00FF};
    vecs[1] = '{7'h01, 8'h01, 1'b0, 16'h01FF};
    vecs[2] = '{7'h02, 8'h00, 1'b0, 16'h01FF};
    vecs[3] = '{7'h05, 8'hAA, 1'b1, 16'h01FF};
    vecs[4] = '{7'h7F, 8'h55, 1'b1, 16'h01FF};
    vecs[5] = '{7'h01, 8'h80, 1'b0, 16'h80FF};
    vecs[6] = '{7'h00, 8'h0F, 1'b0, 16'h800F};
    vecs[7] = '{7'h03, 8'h80, 1'b0, 16'h000F};
    vecs[8] = '{7'h04, 8'hFF, 1'b0, 16'h000F};
    vecs[9] = '{7'h03, 8'h00, 1'b0, 16'h800F};

    reset_and_count("init");
    @(negedge clk);
    chk("pps_one_cycle", pwm_period_start, 0);

    for (int unsigned i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].data);
      chk($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
      @(negedge clk);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d_err_clear", i), wr_err, 0);
    end

    // duty 0x80 / 0x00 / 0xFF on pin 0
    wr(7'h00, 8'h01);
    wr(7'h01, 8'h00);
    wr(7'h02, 8'h01);
    wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    wait_pps("pps_d80");
    measure(1'b0, 8'h00, hi, trans, first, last);
    chk("d80_high", hi, 1664);
    chk("d80_trans", trans, 1);
    chk("d80_first", first, 1);
    chk("d80_last", last, 0);
    chk("d80_upper_bits", out[15:1], 0);
    chk("d80_period_len", pwm_period_start, 1);

    wr(7'h04, 8'h00);
    wait_pps("pps_d00");
    measure(1'b0, 8'h00, hi, trans, first, last);
    chk("d00_high", hi, 0);

    wr(7'h04, 8'hFF);
    wait_pps("pps_dff");
    measure(1'b0, 8'h00, hi, trans, first, last);
    chk("dff_high", hi, PERIOD);
    chk("dff_trans", trans, 0);

    // duty write landing on the boundary edge
    wr(7'h04, 8'h40);
    wait_pps("pps_d40");
    measure(1'b1, 8'hC0, hi, trans, first, last);
    chk("d40_high", hi, 832);
    chk("d40_pps", pwm_period_start, 1);
    measure(1'b0, 8'h00, hi, trans, first, last);
    chk("boundary_write_old_duty", hi, 832);
    chk("boundary_write_pps", pwm_period_start, 1);
    measure(1'b0, 8'h00, hi, trans, first, last);
    chk("boundary_write_new_duty", hi, 2496);

    // back-to-back writes
    wr_valid = 1'b1; wr_addr = 7'h02; wr_data = 8'h00;
    @(negedge clk);
    wr_addr = 7'h03; wr_data = 8'h00;
    @(negedge clk);
    wr_addr = 7'h00; wr_data = 8'hAA;
    @(negedge clk);
    wr_addr = 7'h01; wr_data = 8'h55;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("b2b_err", wr_err, 0);
    @(negedge clk);
    chk("b2b_out", out, 16'h55AA);

    wr_valid = 1'b1; wr_addr = 7'h05; wr_data = 8'hAA;
    @(negedge clk);
    wr_addr = 7'h7F; wr_data = 8'h11;
    chk("b2b_bad_err0", wr_err, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("b2b_bad_err1", wr_err, 1);
    @(negedge clk);
    chk("b2b_bad_err_clear", wr_err, 0);
    chk("b2b_bad_out", out, 16'h55AA);

    // reset mid-period
    wr(7'h00, 8'hFF);
    wr(7'h01, 8'hFF);
    wr(7'h02, 8'hFF);
    wr(7'h03, 8'hFF);
    wr(7'h04, 8'h80);
    wait_pps("pps_pre_reset");
    repeat (100) @(negedge clk);
    chk("pre_reset_out", out, 16'hFFFF);
    reset_and_count("mid");
    wr(7'h00, 8'h01);
    @(negedge clk);
    chk("post_reset_en_pwm_clear", out, 16'h0001);
    wr(7'h02, 8'h01);
    @(negedge clk);
    chk("post_reset_duty_clear", out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
